alu_op_scheduler: RTL and testbench

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

---
 rtl/alu_op_scheduler.sv | 166 ++++++++++++++++
 tb/tb_alu_op_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler that routes four requesters onto shared add/sub/mul/div units.
// Optional macro ALU_SCHED_TIMEOUT_EN adds a WAIT watchdog and a timeout output.
module alu_op_scheduler (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req,
   input  logic [7:0]   req_op,
   input  logic [255:0] req_a,
   input  logic [255:0] req_b,
   output logic [3:0]   unit_start,
   output logic [63:0]  unit_a,
   output logic [63:0]  unit_b,
   input  logic         unit_done,
   input  logic [63:0]  unit_result,
   output logic [3:0]   gnt,
   output logic [63:0]  result,
   output logic         busy
`ifdef ALU_SCHED_TIMEOUT_EN
   ,
   output logic         timeout
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [1:0]  ptr_r;
   logic [1:0]  win_r;
   logic [2:0]  pick_s;
   logic [1:0]  pick_op_s;
   logic        to_hit_s;
   logic [3:0]  start_s;
   logic [3:0]  gnt_s;
   logic [63:0] result_s;

   // Nearest requesting index after ptr wins; the loop runs far-to-near so the closest overwrites.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] pick;
      logic [1:0] idx;
      pick = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = p + 2'(i);
         if (r[idx]) begin
            pick = {1'b1, idx};
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

`ifdef ALU_SCHED_TIMEOUT_EN
   logic [7:0] cnt_r;

   // WAIT-cycle counter; 254 marks the 255th cycle without unit_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= 8'd0;
      end else if (state_r == WAIT) begin
         cnt_r <= cnt_r + 8'd1;
      end else begin
         cnt_r <= 8'd0;
      end
   end

   assign to_hit_s = (state_r == WAIT) && (cnt_r == 8'd254);

   // Timeout flag accompanies the gnt pulse of a watchdog-terminated transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout <= 1'b0;
      end else begin
         timeout <= (state_s == RESP) && !unit_done;
      end
   end
`else
   assign to_hit_s = 1'b0;
`endif

   assign pick_s    = rr_pick(req, ptr_r);
   assign pick_op_s = req_op[{pick_s[1:0], 1'b0} +: 2];

   // Next-state logic; unit_done only matters in WAIT.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (pick_s[2]) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: state_s = WAIT;
         WAIT: begin
            if (unit_done || to_hit_s) begin
               state_s = RESP;
            end else begin
               state_s = WAIT;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output values for the upcoming state, registered below so outputs align with state.
   always_comb begin
      start_s  = 4'd0;
      gnt_s    = 4'd0;
      result_s = 64'd0;
      if (state_s == ISSUE) begin
         start_s = 4'b0001 << pick_op_s;
      end else begin
         start_s = 4'd0;
      end
      if (state_s == RESP) begin
         gnt_s    = 4'b0001 << win_r;
         result_s = unit_done ? unit_result : {64{1'b1}};
      end else begin
         gnt_s    = 4'd0;
         result_s = 64'd0;
      end
   end

   // State, winner bookkeeping, operand latch and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         ptr_r      <= 2'd3;
         win_r      <= 2'd0;
         unit_a     <= 64'd0;
         unit_b     <= 64'd0;
         unit_start <= 4'd0;
         gnt        <= 4'd0;
         result     <= 64'd0;
         busy       <= 1'b0;
      end else begin
         state_r    <= state_s;
         unit_start <= start_s;
         gnt        <= gnt_s;
         result     <= result_s;
         busy       <= (state_s != IDLE);
         case (state_r)
            IDLE: begin
               if (pick_s[2]) begin
                  win_r  <= pick_s[1:0];
                  unit_a <= req_a[{pick_s[1:0], 6'd0} +: 64];
                  unit_b <= req_b[{pick_s[1:0], 6'd0} +: 64];
               end else begin
                  win_r  <= win_r;
               end
            end
            RESP:    ptr_r <= win_r;
            default: ptr_r <= ptr_r;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed self-checking bench for alu_op_scheduler; honours ALU_SCHED_TIMEOUT_EN if defined.
module tb_alu_op_scheduler;

   localparam logic [7:0] OPS = 8'b11_10_00_01;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [7:0]   req_op;
   logic [255:0] req_a;
   logic [255:0] req_b;
   logic [3:0]   unit_start;
   logic [63:0]  unit_a;
   logic [63:0]  unit_b;
   logic         unit_done;
   logic [63:0]  unit_result;
   logic [3:0]   gnt;
   logic [63:0]  result;
   logic         busy;
`ifdef ALU_SCHED_TIMEOUT_EN
   logic         timeout;
`endif

   int passed = 0;
   int failed = 0;
   int total  = 0;

   alu_op_scheduler dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
      .unit_done(unit_done), .unit_result(unit_result),
      .gnt(gnt), .result(result), .busy(busy)
`ifdef ALU_SCHED_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] lane_a(input int k);
      return 64'd10 + (64'(k) << 32);
   endfunction

   function automatic logic [63:0] lane_b(input int k);
      return 64'd3 + 64'(k);
   endfunction

   function automatic logic [3:0] exp_start(input int k);
      logic [7:0] o;
      o = OPS;
      return 4'b0001 << o[2*k +: 2];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge in IDLE with req already presented; returns at the negedge back in IDLE.
   task automatic txn(input string tag, input int k, input logic drop, input logic [63:0] rv);
      @(negedge clk);
      chk({tag, "_issue_start"}, 64'(unit_start), 64'(exp_start(k)));
      chk({tag, "_issue_a"}, unit_a, lane_a(k));
      chk({tag, "_issue_b"}, unit_b, lane_b(k));
      chk({tag, "_issue_busy"}, 64'(busy), 64'd1);
      chk({tag, "_issue_gnt"}, 64'(gnt), 64'd0);
      if (drop) begin
         req   = 4'd0;
         req_a = ~req_a;
      end
      @(negedge clk);
      chk({tag, "_wait_start"}, 64'(unit_start), 64'd0);
      chk({tag, "_wait_a"}, unit_a, lane_a(k));
      chk({tag, "_wait_result"}, result, 64'd0);
      unit_done   = 1'b1;
      unit_result = rv;
      @(negedge clk);
      chk({tag, "_resp_gnt"}, 64'(gnt), 64'(4'b0001 << k));
      chk({tag, "_resp_result"}, result, rv);
`ifdef ALU_SCHED_TIMEOUT_EN
      chk({tag, "_resp_timeout"}, 64'(timeout), 64'd0);
`endif
      unit_done   = 1'b0;
      unit_result = 64'd0;
      if (drop) req_a = ~req_a;
      @(negedge clk);
      chk({tag, "_idle_gnt"}, 64'(gnt), 64'd0);
      chk({tag, "_idle_result"}, result, 64'd0);
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      rst         = 1'b1;
      req         = 4'd0;
      req_op      = OPS;
      unit_done   = 1'b0;
      unit_result = 64'd0;
      for (int i = 0; i < 4; i++) begin
         req_a[64*i +: 64] = lane_a(i);
         req_b[64*i +: 64] = lane_b(i);
      end
      @(negedge clk);
      chk("rst_start", 64'(unit_start), 64'd0);
      chk("rst_a", unit_a, 64'd0);
      chk("rst_b", unit_b, 64'd0);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single sub on requester 0: a=10, b=3, unit returns 7.
      req = 4'b0001;
      txn("single", 0, 1'b0, 64'd7);
      req = 4'd0;

      // Done during ISSUE must be ignored; requester 3 stays in WAIT.
      req = 4'b1000;
      @(negedge clk);
      chk("iss_done_start", 64'(unit_start), 64'b1000);
      unit_done   = 1'b1;
      unit_result = 64'd99;
      @(negedge clk);
      unit_done   = 1'b0;
      unit_result = 64'd0;
      chk("iss_done_gnt0", 64'(gnt), 64'd0);
      @(negedge clk);
      chk("iss_done_gnt1", 64'(gnt), 64'd0);
      chk("iss_done_busy", 64'(busy), 64'd1);
      unit_done   = 1'b1;
      unit_result = 64'd5;
      @(negedge clk);
      chk("iss_done_resp_gnt", 64'(gnt), 64'b1000);
      chk("iss_done_resp_result", result, 64'd5);
      unit_done   = 1'b0;
      unit_result = 64'd0;
      req         = 4'd0;
      @(negedge clk);

      // All four held: served 0,1,2,3,0.
      req = 4'b1111;
      txn("rr0", 0, 1'b0, 64'h11);
      txn("rr1", 1, 1'b0, 64'h22);
      txn("rr2", 2, 1'b0, 64'h33);
      txn("rr3", 3, 1'b0, 64'h44);
      txn("rr4", 0, 1'b0, 64'h55);

      // Serve 2, then 1001 must pick 3 before wrapping to 0.
      req = 4'b0100;
      txn("wrap_r2", 2, 1'b0, 64'h66);
      req = 4'b1001;
      txn("wrap_r3", 3, 1'b0, 64'h77);
      txn("wrap_r0", 0, 1'b0, 64'h88);
      req = 4'd0;

      // Reset during WAIT of requester 1 aborts it without a grant.
      req = 4'b0010;
      @(negedge clk);
      chk("abort_issue_start", 64'(unit_start), 64'(exp_start(1)));
      @(negedge clk);
      rst = 1'b1;
      req = 4'd0;
      #1;
      chk("abort_start", 64'(unit_start), 64'd0);
      chk("abort_a", unit_a, 64'd0);
      chk("abort_b", unit_b, 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("abort_gnt", 64'(gnt), 64'd0);
      rst       = 1'b0;
      unit_done = 1'b1;
      @(negedge clk);
      chk("idle_done_busy", 64'(busy), 64'd0);
      chk("idle_done_gnt", 64'(gnt), 64'd0);
      unit_done = 1'b0;
      @(negedge clk);
      req = 4'b0011;
      txn("post_rst", 0, 1'b0, 64'h99);
      req = 4'd0;

      // Requester 1 drops req and operands change in flight; still granted with 42.
      req = 4'b0010;
      txn("drop", 1, 1'b1, 64'd42);

      // No unit_done: watchdog when enabled, otherwise WAIT holds.
      req = 4'b0100;
      @(negedge clk);
      chk("to_issue_start", 64'(unit_start), 64'b0100);
      req = 4'd0;
      repeat (255) @(negedge clk);
      chk("to_wait_busy", 64'(busy), 64'd1);
      chk("to_wait_gnt", 64'(gnt), 64'd0);
      @(negedge clk);
`ifdef ALU_SCHED_TIMEOUT_EN
      chk("to_resp_gnt", 64'(gnt), 64'b0100);
      chk("to_resp_result", result, {64{1'b1}});
      chk("to_resp_flag", 64'(timeout), 64'd1);
      @(negedge clk);
      chk("to_idle_flag", 64'(timeout), 64'd0);
      chk("to_idle_busy", 64'(busy), 64'd0);
`else
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_gnt", 64'(gnt), 64'd0);
      unit_done   = 1'b1;
      unit_result = 64'hABCD;
      @(negedge clk);
      chk("hold_resp_gnt", 64'(gnt), 64'b0100);
      chk("hold_resp_result", result, 64'hABCD);
      unit_done   = 1'b0;
      unit_result = 64'd0;
      @(negedge clk);
      chk("hold_idle_busy", 64'(busy), 64'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
